// File: rtl/tl45_pkg.sv
// Shared opcodes, register constants and writeback FSM states.
package tl45_pkg;

  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_BRANCH = 5'h0C;
  localparam logic [3:0] REG_ZERO  = 4'h0;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_MEM,
    WB_FAULT
  } wb_state_t;

endpackage

// File: rtl/tl45_writeback.sv
// Writeback stage: retires ALU results and load data into the DPRF write port,
// mirrors every write onto the operand-forwarding bus, and holds the pipeline
// while a load waits for its memory ack. A watchdog faults the core if the ack
// never arrives.
module tl45_writeback
  import tl45_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pipe_flush,
  output logic              o_pipe_stall,
  input  logic [4:0]        i_opcode,
  input  logic [3:0]        i_dr,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_is_load,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_dprf_we,
  output logic [3:0]        o_dprf_wa,
  output logic [DATA_W-1:0] o_dprf_wd,
  output logic [3:0]        o_of_reg,
  output logic [DATA_W-1:0] o_of_data,
  output logic              o_fault,
  output logic [31:0]       o_retired
);

  localparam int CNT_W = 16;

  wb_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]        r_ld_dr, w_ld_dr_nxt;
  logic              r_we, w_we_nxt;
  logic [3:0]        r_wa, w_wa_nxt;
  logic [DATA_W-1:0] r_wd, w_wd_nxt;
  logic [31:0]       r_retired;
  logic              w_retire;
  logic              w_cnt_last;

  // The wait that would bring the count up to MEM_TIMEOUT is the last one allowed.
  assign w_cnt_last = ({1'b0, r_cnt} + 17'd1) == 17'(MEM_TIMEOUT);

  // Next-state, counter and write-port decisions; defaults hold state and drop we.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ld_dr_nxt = r_ld_dr;
    w_we_nxt    = 1'b0;
    w_wa_nxt    = r_wa;
    w_wd_nxt    = r_wd;
    w_retire    = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (i_opcode != OP_NOP && !i_pipe_flush) begin
          if (i_is_load) begin
            w_state_nxt = WB_WAIT_MEM;
            w_cnt_nxt   = '0;
            w_ld_dr_nxt = i_dr;
          end else begin
            w_retire = 1'b1;
            if (i_dr != REG_ZERO) begin
              w_we_nxt = 1'b1;
              w_wa_nxt = i_dr;
              w_wd_nxt = i_value;
            end
          end
        end
      end
      WB_WAIT_MEM: begin
        // Flush is ignored here: the pending load is older than whatever flushed.
        if (i_mem_ack) begin
          w_state_nxt = WB_IDLE;
          w_retire    = 1'b1;
          if (r_ld_dr != REG_ZERO) begin
            w_we_nxt = 1'b1;
            w_wa_nxt = r_ld_dr;
            w_wd_nxt = i_mem_data;
          end
        end else if (w_cnt_last) begin
          w_state_nxt = WB_FAULT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;  // FAULT is terminal until reset
    endcase
  end

  // State, counter, write port and retire counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= WB_IDLE;
      r_cnt     <= '0;
      r_ld_dr   <= '0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wd      <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ld_dr   <= w_ld_dr_nxt;
      r_we      <= w_we_nxt;
      r_wa      <= w_wa_nxt;
      r_wd      <= w_wd_nxt;
      r_retired <= r_retired + {31'd0, w_retire};
    end
  end

  assign o_pipe_stall = (r_state != WB_IDLE);
  assign o_fault      = (r_state == WB_FAULT);
  assign o_dprf_we    = r_we;
  assign o_dprf_wa    = r_wa;
  assign o_dprf_wd    = r_wd;
  assign o_of_reg     = r_we ? r_wa : REG_ZERO;
  assign o_of_data    = r_wd;
  assign o_retired    = r_retired;

endmodule
